sm_operand_entry: RTL

- Interactive operand-entry block: the input-side counterpart of the sign-magnitude display path.
- Turns debounced button levels into an 8-bit sign-magnitude operand, stepping the signed value by ±1 with hold-to-repeat, sign toggle and clear.
- Output feeds the sign-magnitude adder operand inputs and the hex/7-seg display controller (sign + 7-bit magnitude).

---
 rtl/sm_operand_entry_if.sv | 27 ++
 rtl/sm_operand_entry.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sm_operand_entry_if.sv
//------------------------------------------------------------------------------
// sm_operand_entry_if: button levels in, sign-magnitude operand out.  rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sm_operand_entry_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_sign;
  logic       btn_clr;
  logic [7:0] value;
  logic       sign;
  logic [6:0] mag;
  logic       upd;

  modport master (
    output btn_up, btn_down, btn_sign, btn_clr,
    input  value, sign, mag, upd
  );

  modport slave (
    input  btn_up, btn_down, btn_sign, btn_clr,
    output value, sign, mag, upd
  );
endinterface

`default_nettype wire

// File: rtl/sm_operand_entry.sv
//------------------------------------------------------------------------------
// sm_operand_entry: button-driven 8-bit sign-magnitude operand with hold-to-repeat.  rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sm_operand_entry #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic               clk,
  input  logic               reset,
  sm_operand_entry_if.slave  bus
);

  localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int          TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LOAD = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          dir_up, dir_up_nxt;
  logic [7:0]    value, value_nxt;
  logic          upd;
  logic          prev_up, prev_down, prev_sign, prev_clr;
  logic          armed;

  logic up_edge, down_edge, sign_edge, clr_edge;
  logic both_held, active_held;

  function automatic logic [7:0] step_up(input logic [7:0] v);
    if (!v[7])
      return (v[6:0] == 7'h7F) ? v : {1'b0, v[6:0] + 7'd1};
    else if (v[6:0] == 7'd1)
      return 8'h00;
    else
      return {1'b1, v[6:0] - 7'd1};
  endfunction

  function automatic logic [7:0] step_down(input logic [7:0] v);
    if (v[7])
      return (v[6:0] == 7'h7F) ? v : {1'b1, v[6:0] + 7'd1};
    else if (v[6:0] == 7'd0)
      return 8'h81;
    else
      return {1'b0, v[6:0] - 7'd1};
  endfunction

  // The first sample after reset only primes the edge registers, so a button
  // held across reset release never counts as a press.
  assign up_edge     = armed & bus.btn_up   & ~prev_up;
  assign down_edge   = armed & bus.btn_down & ~prev_down;
  assign sign_edge   = armed & bus.btn_sign & ~prev_sign;
  assign clr_edge    = armed & bus.btn_clr  & ~prev_clr;
  assign both_held   = bus.btn_up & bus.btn_down;
  assign active_held = dir_up ? bus.btn_up : bus.btn_down;

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    dir_up_nxt = dir_up;
    value_nxt  = value;

    if (clr_edge) begin
      value_nxt = 8'h00;
      state_nxt = IDLE;
      timer_nxt = '0;
    end else if (sign_edge) begin
      if (value[6:0] != 7'd0)
        value_nxt = {~value[7], value[6:0]};
      state_nxt = IDLE;
      timer_nxt = '0;
    end else if (both_held) begin
      state_nxt = IDLE;
      timer_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (up_edge) begin
            value_nxt  = step_up(value);
            dir_up_nxt = 1'b1;
            timer_nxt  = HOLD_LOAD;
            state_nxt  = HOLD;
          end else if (down_edge) begin
            value_nxt  = step_down(value);
            dir_up_nxt = 1'b0;
            timer_nxt  = HOLD_LOAD;
            state_nxt  = HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!active_held) begin
            state_nxt = IDLE;
            timer_nxt = '0;
          end else if (timer == '0) begin
            value_nxt = dir_up ? step_up(value) : step_down(value);
            timer_nxt = REPEAT_LOAD;
            state_nxt = REPEAT;
          end else begin
            timer_nxt = timer - TW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      dir_up    <= 1'b0;
      value     <= 8'h00;
      upd       <= 1'b0;
      prev_up   <= 1'b0;
      prev_down <= 1'b0;
      prev_sign <= 1'b0;
      prev_clr  <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      dir_up    <= dir_up_nxt;
      value     <= value_nxt;
      upd       <= (value_nxt != value);
      prev_up   <= bus.btn_up;
      prev_down <= bus.btn_down;
      prev_sign <= bus.btn_sign;
      prev_clr  <= bus.btn_clr;
      armed     <= 1'b1;
    end
  end

  assign bus.value = value;
  assign bus.sign  = value[7];
  assign bus.mag   = value[6:0];
  assign bus.upd   = upd;

endmodule

`default_nettype wire
